regfile_op_sequencer: RTL and testbench

Multi-cycle micro-sequencer that drives the 8x8 two-read/one-write register file.
- Accepts one register-to-register instruction at a time over a valid/ready handshake.
- Reads two source registers, computes an 8-bit ALU result, and writes it back through the single write port.
- Sits between an instruction source (testbench or small fetch unit) and the register file. It is the only master of the file's WEN/RW/busW/RX/RY.

---
 rtl/regseq_pkg.sv | 25 ++
 rtl/regseq_alu.sv | 49 ++++
 rtl/regfile_op_sequencer.sv | 111 +++++++++++
 tb/tb_regfile_op_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regseq_pkg.sv
// regseq_pkg: shared definitions for the register-file op sequencer.
//   - DATA_W_DEF / ADDR_W_DEF / OP_W_DEF : default widths
//   - OP_NOP..OP_LDI                     : opcode encoding
//   - S_IDLE..S_WB                       : 2-bit FSM state encoding
package regseq_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned OP_W_DEF   = 3;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

endpackage

// File: rtl/regseq_alu.sv
// regseq_alu: purely combinational ALU for the op sequencer.
// Ports:
//   op_i     : opcode (see regseq_pkg)
//   x_i, y_i : operands
//   imm_i    : immediate, used by LDI only
//   result_o : computed result
// Build option REGSEQ_SAT_EN: when defined, ADD/SUB saturate unsigned
// (ADD clamps to all-ones on carry-out, SUB clamps to zero on borrow);
// otherwise they wrap modulo 2^DATA_W.
module regseq_alu
    import regseq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o
);

    // Extra top bit carries the ADD carry-out / SUB borrow.
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, x_i} + {1'b0, y_i};
    assign diff = {1'b0, x_i} - {1'b0, y_i};

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_NOP: result_o = '0;
`ifdef REGSEQ_SAT_EN
            OP_ADD: result_o = sum[DATA_W]  ? '1 : sum[DATA_W-1:0];
            OP_SUB: result_o = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
            OP_ADD: result_o = sum[DATA_W-1:0];
            OP_SUB: result_o = diff[DATA_W-1:0];
`endif
            OP_AND: result_o = x_i & y_i;
            OP_OR:  result_o = x_i | y_i;
            OP_XOR: result_o = x_i ^ y_i;
            OP_SLT: result_o = {{(DATA_W-1){1'b0}}, diff[DATA_W]};
            OP_LDI: result_o = imm_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: multi-cycle micro-sequencer driving an 8x8
// two-read/one-write register file. One instruction at a time:
// IDLE -> READ -> EXEC -> WB -> IDLE, one cycle each.
// Ports:
//   Clk, Rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : instruction handshake (ready only in IDLE)
//   in_op/rd/rs/rt/imm   : instruction fields
//   WEN/RW/busW          : register file write port (driven in WB)
//   RX/RY, busX/busY     : register file read ports
//   done                 : one-cycle retire pulse
//   result               : last computed result, held until next retire
// Build option REGSEQ_SAT_EN (in regseq_alu): saturating ADD/SUB.
// All outputs decode from registers only.
module regfile_op_sequencer
    import regseq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [DATA_W-1:0] in_imm,
    output logic              WEN,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] busW,
    output logic [ADDR_W-1:0] RX,
    output logic [ADDR_W-1:0] RY,
    input  logic [DATA_W-1:0] busX,
    input  logic [DATA_W-1:0] busY,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    logic [1:0]        state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] rd_q, rs_q, rt_q;
    logic [DATA_W-1:0] imm_q, x_q, y_q, result_q;
    logic [DATA_W-1:0] alu_result;
    logic              accept;

    assign accept = in_valid && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    regseq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (op_q[2:0]),
        .x_i      (x_q),
        .y_i      (y_q),
        .imm_i    (imm_q),
        .result_o (alu_result)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= in_op;
                rd_q  <= in_rd;
                rs_q  <= in_rs;
                rt_q  <= in_rt;
                imm_q <= in_imm;
            end
            if (state_q == S_READ) begin
                x_q <= busX;
                y_q <= busY;
            end
            if (state_q == S_EXEC) begin
                result_q <= alu_result;
            end
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign done     = (state_q == S_WB);
    // r0 is never written; NOP retires without touching the file.
    assign WEN      = (state_q == S_WB) && (op_q[2:0] != OP_NOP) && (rd_q != '0);
    assign RW       = rd_q;
    assign busW     = result_q;
    assign RX       = rs_q;
    assign RY       = rt_q;
    assign result   = result_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
module tb_regfile_op_sequencer;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op, in_rd, in_rs, in_rt;
    logic [7:0] in_imm;
    logic       WEN;
    logic [2:0] RW, RX, RY;
    logic [7:0] busW, busX, busY;
    logic       done;
    logic [7:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    // Register file seen by the DUT, and the bench's expected contents.
    logic [7:0] rf  [8];
    logic [7:0] mrf [8];

    always #5 Clk = ~Clk;

    regfile_op_sequencer dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .in_imm   (in_imm),
        .WEN      (WEN),
        .RW       (RW),
        .busW     (busW),
        .RX       (RX),
        .RY       (RY),
        .busX     (busX),
        .busY     (busY),
        .done     (done),
        .result   (result)
    );

    assign busX = rf[RX];
    assign busY = rf[RY];

    always @(posedge Clk) begin
        if (WEN) rf[RW] <= busW;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU from the opcode definitions, using plain integer arithmetic.
    function automatic logic [7:0] ref_alu(input int op, input int x, input int y, input int imm);
        int r;
        case (op)
`ifdef REGSEQ_SAT_EN
            1: r = (x + y > 255) ? 255 : x + y;
            2: r = (x < y) ? 0 : x - y;
`else
            1: r = (x + y) % 256;
            2: r = (x - y + 256) % 256;
`endif
            3: r = x & y;
            4: r = x | y;
            5: r = x ^ y;
            6: r = (x < y) ? 1 : 0;
            7: r = imm;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                             input logic [2:0] rt, input logic [7:0] imm,
                             input logic chk_res, input logic [7:0] exp_res);
        int   waitc = 0;
        logic exp_wen;
        @(negedge Clk);
        while (!in_ready && waitc < 10) begin
            @(negedge Clk);
            waitc++;
        end
        chk("ready_before_issue", in_ready, 1);
        in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        in_op = 3'($urandom); in_rd = 3'($urandom); in_imm = 8'($urandom);
        exp_wen = (op != 3'd0) && (rd != 3'd0);
        // READ
        chk("read_ready", in_ready, 0);
        chk("read_wen", WEN, 0);
        chk("read_done", done, 0);
        chk("read_rx", RX, rs);
        chk("read_ry", RY, rt);
        @(posedge Clk); #1;
        // EXEC
        chk("exec_ready", in_ready, 0);
        chk("exec_wen", WEN, 0);
        chk("exec_done", done, 0);
        @(posedge Clk); #1;
        // WB
        chk("wb_ready", in_ready, 0);
        chk("wb_done", done, 1);
        chk("wb_wen", WEN, exp_wen);
        if (exp_wen) chk("wb_rw", RW, rd);
        if (chk_res) begin
            chk("wb_busw", busW, exp_res);
            chk("wb_result", result, exp_res);
        end
        if (exp_wen) mrf[rd] = exp_res;
        @(posedge Clk); #1;
        chk("post_ready", in_ready, 1);
        chk("post_done", done, 0);
        chk("post_wen", WEN, 0);
        chk("post_rf", rf[rd], mrf[rd]);
        if (chk_res) chk("post_result_held", result, exp_res);
    endtask

    typedef struct {
        logic [2:0] op, rd, rs, rt;
        logic [7:0] imm;
        logic       chk_res;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b2b_exp [3];
        int         hs_c [3];
        int         idx, ret;
        logic [7:0] r6_before;

        for (int i = 0; i < 8; i++) begin
            rf[i]  = 8'h00;
            mrf[i] = 8'h00;
        end
        Rst = 1'b1; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;
        #1;
        chk("reset_ready", in_ready, 1);
        chk("reset_wen", WEN, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        @(negedge Clk); @(negedge Clk);
        Rst = 1'b0;

        // Directed table
        //            op    rd    rs    rt    imm    chk   exp
        tbl[0]  = '{3'd7, 3'd1, 3'd0, 3'd0, 8'h2A, 1'b1, 8'h2A};
        tbl[1]  = '{3'd7, 3'd1, 3'd0, 3'd0, 8'hF0, 1'b1, 8'hF0};
        tbl[2]  = '{3'd7, 3'd2, 3'd0, 3'd0, 8'h20, 1'b1, 8'h20};
`ifdef REGSEQ_SAT_EN
        tbl[3]  = '{3'd1, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 8'hFF};
        tbl[4]  = '{3'd2, 3'd4, 3'd2, 3'd1, 8'h00, 1'b1, 8'h00};
`else
        tbl[3]  = '{3'd1, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 8'h10};
        tbl[4]  = '{3'd2, 3'd4, 3'd2, 3'd1, 8'h00, 1'b1, 8'h30};
`endif
        tbl[5]  = '{3'd6, 3'd5, 3'd2, 3'd1, 8'h00, 1'b1, 8'h01};
        tbl[6]  = '{3'd7, 3'd0, 3'd0, 3'd0, 8'h55, 1'b1, 8'h55};
        tbl[7]  = '{3'd0, 3'd6, 3'd1, 3'd2, 8'h99, 1'b0, 8'h00};
        tbl[8]  = '{3'd3, 3'd6, 3'd1, 3'd2, 8'h00, 1'b1, 8'h20};
        tbl[9]  = '{3'd4, 3'd7, 3'd1, 3'd2, 8'h00, 1'b1, 8'hF0};
        tbl[10] = '{3'd5, 3'd6, 3'd1, 3'd2, 8'h00, 1'b1, 8'hD0};
        // Source equals destination: old value is read before the write.
        tbl[11] = '{3'd2, 3'd3, 3'd3, 3'd3, 8'h00, 1'b1, 8'h00};

        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].imm,
                      tbl[i].chk_res, tbl[i].exp);
        end
        chk("r0_never_written", rf[0], 0);

        // in_valid held high: three instructions, accepted only in IDLE
        b2b_exp[0] = 8'h11; b2b_exp[1] = 8'h22; b2b_exp[2] = 8'h33;
        idx = 0; ret = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (done) begin
                if (ret < 3) begin
                    chk("b2b_busw", busW, b2b_exp[ret]);
                    chk("b2b_retire_cycle", c, hs_c[ret] + 3);
                end
                ret++;
            end
            if (in_ready) begin
                if (idx < 3) begin
                    in_valid = 1'b1;
                    in_op  = (idx == 2) ? 3'd1 : 3'd7;
                    in_rd  = 3'(idx + 1);
                    in_rs  = 3'd1;
                    in_rt  = 3'd2;
                    in_imm = (idx == 0) ? 8'h11 : 8'h22;
                    hs_c[idx] = c;
                    if (idx > 0) chk("b2b_spacing", c - hs_c[idx-1], 4);
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                in_op = 3'($urandom); in_rd = 3'($urandom);
                in_rs = 3'($urandom); in_rt = 3'($urandom); in_imm = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("b2b_accepted", idx, 3);
        chk("b2b_retire_count", ret, 3);
        mrf[1] = 8'h11; mrf[2] = 8'h22; mrf[3] = 8'h33;
        for (int i = 1; i < 4; i++) chk("b2b_rf", rf[i], mrf[i]);

        // Reset during EXEC aborts the instruction
        r6_before = mrf[6];
        @(negedge Clk);
        in_op = 3'd1; in_rd = 3'd6; in_rs = 3'd1; in_rt = 3'd2; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        #1;
        chk("rst_exec_ready", in_ready, 1);
        chk("rst_exec_wen", WEN, 0);
        chk("rst_exec_done", done, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("rst_hold_done", done, 0);
            chk("rst_hold_wen", WEN, 0);
        end
        Rst = 1'b0;
        #1;
        chk("rst_release_ready", in_ready, 1);
        chk("rst_release_result", result, 0);
        chk("rst_r6_unchanged", rf[6], r6_before);
        run_instr(3'd7, 3'd6, 3'd0, 3'd0, 8'h77, 1'b1, 8'h77);

        // Reset asserted in WB drops WEN at once and blocks the write
        @(negedge Clk);
        in_op = 3'd7; in_rd = 3'd7; in_imm = 8'hAB; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;
        chk("wb_rst_wen_before", WEN, 1);
        Rst = 1'b1;
        #1;
        chk("wb_rst_wen_async", WEN, 0);
        chk("wb_rst_done_async", done, 0);
        @(negedge Clk); @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("wb_rst_r7_unchanged", rf[7], mrf[7]);

        // Randomized instructions against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [2:0] op, rd, rs, rt;
            logic [7:0] imm;
            op  = 3'($urandom_range(0, 7));
            rd  = 3'($urandom_range(0, 7));
            rs  = 3'($urandom_range(0, 7));
            rt  = 3'($urandom_range(0, 7));
            imm = 8'($urandom);
            run_instr(op, rd, rs, rt, imm, op != 3'd0,
                      ref_alu(int'(op), int'(mrf[rs]), int'(mrf[rt]), int'(imm)));
        end
        for (int i = 0; i < 8; i++) chk("final_rf", rf[i], mrf[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
